// File: rtl/ex_mem_req.sv
// Execute-side memory-request stage: holds one instruction, computes store lanes and
// misalignment, issues the data-memory address request, and hands off to writeback.
module ex_mem_req #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cancel,
    input  logic                  hold,
    input  logic                  valid_id,
    input  logic                  ready_go_id,
    output logic                  allow_in_ex,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [3:0]            control_flow_id,
    input  logic [RD_WIDTH-1:0]   rd_id,
    input  logic [2:0]            ins_func3_id,
    input  logic                  fence_type_id,
    input  logic                  wb_busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_addr_ok,
    output logic                  valid_ex,
    output logic                  ready_go_ex,
    input  logic                  allow_in_wb,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [3:0]            control_flow_ex,
    output logic [RD_WIDTH-1:0]   rd_ex,
    output logic [2:0]            ins_func3_o,
    output logic                  fence_type_ex,
    output logic                  misalign_ex
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [DATA_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] rs2_r;
    logic [3:0]            cf_r;
    logic [RD_WIDTH-1:0]   rd_r;
    logic [2:0]            func3_r;
    logic                  fence_r;

    logic                  full;
    logic                  is_mem;
    logic                  misalign_rule;
    logic                  fence_block;
    logic                  req_ok;
    logic                  commit;
    logic [1:0]            offset;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload capture; loads only when an instruction is accepted from upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            rs2_r   <= '0;
            cf_r    <= '0;
            rd_r    <= '0;
            func3_r <= '0;
            fence_r <= 1'b0;
        end else if (req_ok) begin
            addr_r  <= alu_result_i;
            rs2_r   <= rs2_data_i;
            cf_r    <= control_flow_id;
            rd_r    <= rd_id;
            func3_r <= ins_func3_id;
            fence_r <= fence_type_id;
        end
    end

    // Handshake, misalignment, request gating and next-state decode
    always_comb begin
        full          = 1'b0;
        is_mem        = 1'b0;
        misalign_rule = 1'b0;
        fence_block   = 1'b0;
        misalign_ex   = 1'b0;
        mem_req       = 1'b0;
        ready_go_ex   = 1'b0;
        commit        = 1'b0;
        allow_in_ex   = 1'b0;
        req_ok        = 1'b0;
        state_nxt     = state;

        full        = (state == FULL);
        is_mem      = cf_r[1] | cf_r[2];
        fence_block = fence_r & wb_busy;

        case (func3_r[1:0])
            2'b00:   misalign_rule = 1'b0;
            2'b01:   misalign_rule = addr_r[0];
            2'b10:   misalign_rule = (addr_r[1:0] != 2'b00);
            default: misalign_rule = 1'b1;
        endcase

        misalign_ex = full & is_mem & misalign_rule;
        // Request only when writeback can take the instruction in the same cycle
        mem_req     = full & is_mem & ~misalign_ex & ~hold & ~cancel & allow_in_wb & ~fence_block;
        ready_go_ex = full & ~hold & ~cancel & ~fence_block & (~is_mem | misalign_ex | mem_addr_ok);
        commit      = ready_go_ex & allow_in_wb;
        allow_in_ex = ~full | (commit & ~cancel);
        req_ok      = valid_id & ready_go_id & allow_in_ex;

        case (state)
            EMPTY: begin
                if (req_ok) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (cancel) begin
                    state_nxt = EMPTY;
                end else if (commit && !req_ok) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Store byte-lane replication and strobes
    always_comb begin
        offset    = addr_r[1:0];
        mem_wdata = rs2_r;
        mem_wstrb = 4'b0000;
        case (func3_r[1:0])
            2'b00: begin
                mem_wdata = {(DATA_WIDTH/8){rs2_r[7:0]}};
                mem_wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                mem_wdata = {(DATA_WIDTH/16){rs2_r[15:0]}};
                mem_wstrb = 4'b0011 << offset;
            end
            default: begin
                mem_wdata = rs2_r;
                mem_wstrb = 4'b1111;
            end
        endcase
        if (!cf_r[2]) begin
            mem_wstrb = 4'b0000;
        end
    end

    // Forwarded payload; a misaligned op drops its load/store/write-back effects
    always_comb begin
        valid_ex        = (state == FULL);
        mem_we          = cf_r[2];
        mem_addr        = {addr_r[DATA_WIDTH-1:2], 2'b00};
        mem_address_o   = addr_r;
        control_flow_ex = misalign_ex ? {cf_r[3], 3'b000} : cf_r;
        rd_ex           = rd_r;
        ins_func3_o     = func3_r;
        fence_type_ex   = fence_r;
    end

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed self-checking bench for ex_mem_req.
module tb_ex_mem_req;

    logic        clk;
    logic        rst_n;
    logic        cancel;
    logic        hold;
    logic        valid_id;
    logic        ready_go_id;
    logic        allow_in_ex;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_data_i;
    logic [3:0]  control_flow_id;
    logic [4:0]  rd_id;
    logic [2:0]  ins_func3_id;
    logic        fence_type_id;
    logic        wb_busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        valid_ex;
    logic        ready_go_ex;
    logic        allow_in_wb;
    logic [31:0] mem_address_o;
    logic [3:0]  control_flow_ex;
    logic [4:0]  rd_ex;
    logic [2:0]  ins_func3_o;
    logic        fence_type_ex;
    logic        misalign_ex;

    int checks = 0;
    int errors = 0;

    ex_mem_req #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .cancel(cancel), .hold(hold),
        .valid_id(valid_id), .ready_go_id(ready_go_id), .allow_in_ex(allow_in_ex),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
        .control_flow_id(control_flow_id), .rd_id(rd_id), .ins_func3_id(ins_func3_id),
        .fence_type_id(fence_type_id), .wb_busy(wb_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok),
        .valid_ex(valid_ex), .ready_go_ex(ready_go_ex), .allow_in_wb(allow_in_wb),
        .mem_address_o(mem_address_o), .control_flow_ex(control_flow_ex), .rd_ex(rd_ex),
        .ins_func3_o(ins_func3_o), .fence_type_ex(fence_type_ex), .misalign_ex(misalign_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction while the stage is accepting and capture it
    task automatic issue(input logic [31:0] addr, input logic [31:0] rs2, input logic [3:0] cf,
                         input logic [4:0] rd, input logic [2:0] f3, input logic fence);
        valid_id        = 1'b1;
        ready_go_id     = 1'b1;
        alu_result_i    = addr;
        rs2_data_i      = rs2;
        control_flow_id = cf;
        rd_id           = rd;
        ins_func3_id    = f3;
        fence_type_id   = fence;
        cyc();
        valid_id        = 1'b0;
        ready_go_id     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cancel = 1'b0; hold = 1'b0; valid_id = 1'b0; ready_go_id = 1'b0;
        alu_result_i = '0; rs2_data_i = '0; control_flow_id = '0; rd_id = '0;
        ins_func3_id = '0; fence_type_id = 1'b0; wb_busy = 1'b0; mem_addr_ok = 1'b0;
        allow_in_wb = 1'b0;

        // Reset state
        #12;
        chk("rst_valid_ex", valid_ex, 0);
        chk("rst_allow_in_ex", allow_in_ex, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_address_o", mem_address_o, 0);
        chk("rst_ready_go_ex", ready_go_ex, 0);
        rst_n = 1'b1;
        cyc();

        // LW 0x1004: request and handoff in the same cycle
        allow_in_wb = 1'b1;
        issue(32'h0000_1004, 32'h0, 4'b0011, 5'd3, 3'b010, 1'b0);
        mem_addr_ok = 1'b1;
        #1;
        chk("lw_valid_ex", valid_ex, 1);
        chk("lw_mem_req", mem_req, 1);
        chk("lw_mem_addr", mem_addr, 32'h0000_1004);
        chk("lw_mem_wstrb", mem_wstrb, 0);
        chk("lw_mem_we", mem_we, 0);
        chk("lw_ready_go_ex", ready_go_ex, 1);
        chk("lw_rd_ex", rd_ex, 3);
        chk("lw_misalign", misalign_ex, 0);
        cyc();
        #1;
        chk("lw_empty_after", valid_ex, 0);

        // SB 0x2003
        mem_addr_ok = 1'b0;
        issue(32'h0000_2003, 32'hAABB_CCDD, 4'b0100, 5'd0, 3'b000, 1'b0);
        #1;
        chk("sb_mem_req", mem_req, 1);
        chk("sb_mem_wdata", mem_wdata, 32'hDDDD_DDDD);
        chk("sb_mem_wstrb", mem_wstrb, 4'b1000);
        chk("sb_mem_we", mem_we, 1);
        chk("sb_mem_addr", mem_addr, 32'h0000_2000);
        chk("sb_ready_wait", ready_go_ex, 0);
        mem_addr_ok = 1'b1;
        #1;
        chk("sb_ready_ok", ready_go_ex, 1);
        cyc();
        mem_addr_ok = 1'b0;

        // SH 0x2001 is misaligned: no request, passes straight through
        issue(32'h0000_2001, 32'hAABB_CCDD, 4'b0101, 5'd0, 3'b001, 1'b0);
        #1;
        chk("sh_mis_misalign", misalign_ex, 1);
        chk("sh_mis_mem_req", mem_req, 0);
        chk("sh_mis_ready", ready_go_ex, 1);
        chk("sh_mis_cf_ex", control_flow_ex, 4'b0000);
        chk("sh_mis_addr_o", mem_address_o, 32'h0000_2001);
        cyc();

        // SH 0x2002 aligned: upper half lanes
        issue(32'h0000_2002, 32'hAABB_CCDD, 4'b0100, 5'd0, 3'b001, 1'b0);
        #1;
        chk("sh_mem_wdata", mem_wdata, 32'hCCDD_CCDD);
        chk("sh_mem_wstrb", mem_wstrb, 4'b1100);
        chk("sh_misalign", misalign_ex, 0);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;

        // LW 0x3008 with writeback blocked, then memory stalling
        allow_in_wb = 1'b0;
        issue(32'h0000_3008, 32'h0, 4'b0011, 5'd7, 3'b010, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_wb_mem_req", mem_req, 0);
            chk("stall_wb_valid", valid_ex, 1);
            cyc();
        end
        allow_in_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ok_mem_req", mem_req, 1);
            chk("stall_ok_addr", mem_addr, 32'h0000_3008);
            chk("stall_ok_ready", ready_go_ex, 0);
            cyc();
        end
        mem_addr_ok = 1'b1;
        #1;
        chk("stall_acc_mem_req", mem_req, 1);
        chk("stall_acc_ready", ready_go_ex, 1);
        chk("stall_acc_rd", rd_ex, 7);
        cyc();
        #1;
        chk("stall_empty", valid_ex, 0);

        // Hold suppresses request and freezes the stage
        mem_addr_ok = 1'b0;
        issue(32'h0000_5000, 32'h0, 4'b0011, 5'd9, 3'b010, 1'b0);
        hold = 1'b1;
        mem_addr_ok = 1'b1;
        #1;
        chk("hold_mem_req", mem_req, 0);
        chk("hold_ready", ready_go_ex, 0);
        cyc();
        #1;
        chk("hold_still_full", valid_ex, 1);
        hold = 1'b0;
        #1;
        chk("hold_release_req", mem_req, 1);
        cyc();
        mem_addr_ok = 1'b0;

        // Cancel while a LW waits with mem_addr_ok high
        issue(32'h0000_4000, 32'h0, 4'b0011, 5'd4, 3'b010, 1'b0);
        mem_addr_ok = 1'b1;
        cancel = 1'b1;
        #1;
        chk("cancel_mem_req", mem_req, 0);
        chk("cancel_ready", ready_go_ex, 0);
        chk("cancel_allow_in", allow_in_ex, 0);
        cyc();
        cancel = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        chk("cancel_empty", valid_ex, 0);

        // Fence waits for writeback to drain
        wb_busy = 1'b1;
        issue(32'h0, 32'h0, 4'b1000, 5'd0, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fence_busy_ready", ready_go_ex, 0);
            cyc();
        end
        wb_busy = 1'b0;
        #1;
        chk("fence_free_ready", ready_go_ex, 1);
        chk("fence_flag", fence_type_ex, 1);
        // Back-to-back: ALU op captured while the fence commits
        valid_id = 1'b1; ready_go_id = 1'b1; alu_result_i = 32'h1234_5678;
        control_flow_id = 4'b0001; rd_id = 5'd12; ins_func3_id = 3'b000; fence_type_id = 1'b0;
        #1;
        chk("b2b_allow_in", allow_in_ex, 1);
        cyc();
        valid_id = 1'b0; ready_go_id = 1'b0;
        // Non-fence ignores wb_busy
        wb_busy = 1'b1;
        allow_in_wb = 1'b0;
        #1;
        chk("b2b_full", valid_ex, 1);
        chk("b2b_rd", rd_ex, 12);
        chk("alu_ready_busy", ready_go_ex, 1);
        chk("alu_cf_ex", control_flow_ex, 4'b0001);
        cyc();
        wb_busy = 1'b0;

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_ex", valid_ex, 0);
        chk("arst_allow_in", allow_in_ex, 1);
        chk("arst_mem_address_o", mem_address_o, 0);
        chk("arst_cf_ex", control_flow_ex, 0);
        chk("arst_rd_ex", rd_ex, 0);
        chk("arst_ready", ready_go_ex, 0);
        #3;
        rst_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_req.md
Name: ex_mem_req

Overview:
- Execute-side memory-request stage. Sits directly upstream of the writeback stage (ex_wb).
- Latches one instruction from the decode/execute handoff and computes store byte lanes and misalignment.
- Issues the data-memory address request using the addr_ok handshake, then hands the instruction to writeback in the same cycle the request is accepted.
- Never leaves an accepted request without an owner: the response always belongs to the instruction now in writeback.

Parameters:
DATA_WIDTH, 32, datapath and address width
RD_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cancel  in  1  flush of this stage (branch/trap)
hold  in  1  pipeline freeze
valid_id  in  1  upstream stage holds valid instruction
ready_go_id  in  1  upstream instruction may advance
allow_in_ex  out  1  this stage can accept
alu_result_i  in  DATA_WIDTH  effective address or ALU result
rs2_data_i  in  DATA_WIDTH  store source data
control_flow_id  in  4  [0] write_reg, [1] load, [2] store, [3] pass-through
rd_id  in  RD_WIDTH  destination register
ins_func3_id  in  3  access size/sign
fence_type_id  in  1  fence instruction
wb_busy  in  1  writeback holds an instruction with an outstanding load
mem_req  out  1  memory request valid
mem_we  out  1  request is a store
mem_addr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_wstrb  out  4  byte strobes (0 for loads)
mem_addr_ok  in  1  memory accepts request this cycle
valid_ex  out  1  stage full
ready_go_ex  out  1  instruction may leave
allow_in_wb  in  1  writeback can accept
mem_address_o  out  DATA_WIDTH  full unaligned address/result to writeback
control_flow_ex  out  4  forwarded control bits
rd_ex  out  RD_WIDTH  forwarded rd
ins_func3_o  out  3  forwarded func3
fence_type_ex  out  1  forwarded fence flag
misalign_ex  out  1  held instruction is a misaligned load/store

Behaviour:
- Reset (async, rst_n=0):
  - State EMPTY.
  - All registered payload (address, rs2, control_flow, rd, func3, fence) cleared to 0.
  - All outputs 0, except allow_in_ex=1.
- FSM has two states:
  - EMPTY -> FULL when req_ok = valid_id && ready_go_id && allow_in_ex.
  - FULL -> EMPTY on cancel, or on commit = ready_go_ex && allow_in_wb with no req_ok.
  - FULL stays FULL when commit and req_ok coincide (back-to-back).
- allow_in_ex = EMPTY || (commit && !cancel). Payload registers load on req_ok only.
- valid_ex = FULL.
- is_mem = control_flow[1] | control_flow[2].
- Misalignment by func3[1:0]:
  - 00: never misaligned.
  - 01: misaligned if addr[0].
  - 10: misaligned if addr[1:0] != 0.
  - 11: always misaligned.
  - misalign_ex = FULL && is_mem && (misalignment rule).
- mem_req = FULL && is_mem && !misalign_ex && !hold && !cancel && allow_in_wb && !(fence_type && wb_busy). Combinational; the request is driven only when writeback can take the instruction that same cycle.
- ready_go_ex = FULL && !hold && !cancel && !(fence_type && wb_busy) && (!is_mem || misalign_ex || mem_addr_ok).
- A memory op with mem_req high and mem_addr_ok low stays FULL with the payload unchanged. It re-requests with identical addr/wdata/wstrb each cycle until accepted.
- Store lanes (offset = addr[1:0]):
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << offset.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 << offset.
  - SW: wdata = rs2, wstrb = 4'b1111.
  - Loads: wstrb = 0.
- mem_we = control_flow[2].
- Misaligned op: no request issued. control_flow_ex[2:0] forced to 0 (no load/store/write-back); misalign_ex is visible while FULL.
- Fence: ready_go_ex is suppressed while wb_busy is high. Non-fence instructions ignore wb_busy.
- cancel has priority over hold and commit:
  - Forces mem_req=0 and ready_go_ex=0 the same cycle.
  - State goes to EMPTY next cycle.
  - A request whose mem_addr_ok coincides with cancel is not issued, because mem_req is already 0.
- hold freezes state and payload, and suppresses mem_req and ready_go_ex.

Test Plan:
- LW, addr 0x1004, allow_in_wb=1, mem_addr_ok=1 in the cycle after capture -> mem_req=1, mem_addr=0x1004, wstrb=0; ready_go_ex=1 the same cycle; EMPTY next cycle unless a new instruction is captured.
- SB, addr 0x2003, rs2=0xAABBCCDD -> wdata=0xDDDDDDDD, wstrb=4'b1000, mem_we=1, mem_addr=0x2000.
- SH, addr 0x2001 -> misalign_ex=1, mem_req stays 0, ready_go_ex=1, control_flow_ex[2:0]=0.
- LW with mem_addr_ok low for 3 cycles -> request stable for 4 cycles, accepted on the 4th; allow_in_wb=0 for 2 cycles first -> mem_req stays 0 throughout those cycles.
- Cancel asserted while a LW is waiting with mem_addr_ok=1 -> mem_req=0 that cycle, EMPTY next cycle, no handoff.
- Fence with wb_busy=1 for 5 cycles -> ready_go_ex=0 for 5 cycles, then 1; async rst_n low mid-operation -> immediate EMPTY, all outputs 0, allow_in_ex=1.
